// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: per-channel debounce, edge ticks
// selected by mode, sticky pending flags and a registered interrupt.

module multi_edge_detector_ch #(
  parameter int       DEBOUNCE    = 2,
  parameter logic     RESET_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       filtered,
  output logic       tick,
  output logic       pending
);
  localparam int             CW     = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  DEB_M1 = CW'(DEBOUNCE - 1);

  // Moore state lives in {filtered, cnt}: cnt == 0 is STABLE_*, cnt > 0 is PEND_*.
  logic [CW-1:0] cnt;
  logic          accept;
  logic          tick_next;

  assign accept    = sample && (level != filtered) && (cnt == DEB_M1);
  assign tick_next = accept && ((level && mode[0]) || (!level && mode[1]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filtered <= RESET_LEVEL;
      cnt      <= '0;
      tick     <= 1'b0;
      pending  <= 1'b0;
    end else begin
      tick    <= tick_next;
      pending <= (pending & ~clear) | tick_next;
      if (sample) begin
        if (level == filtered) begin
          cnt <= '0;                       // glitch rejected
        end else if (cnt == DEB_M1) begin
          filtered <= level;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module multi_edge_detector #(
  parameter int   CHANNELS    = 4,
  parameter int   DEBOUNCE    = 2,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   filtered,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);
  logic update_prev;
  logic sample;

  // update_prev resets low so a strobe already high after reset still samples.
  assign sample = update & ~update_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_prev <= 1'b0;
      irq         <= 1'b0;
    end else begin
      update_prev <= update;
      irq         <= |pending;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    multi_edge_detector_ch #(
      .DEBOUNCE    (DEBOUNCE),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sample   (sample),
      .level    (level[gi]),
      .mode     (mode[2*gi +: 2]),
      .clear    (clear[gi]),
      .filtered (filtered[gi]),
      .tick     (tick[gi]),
      .pending  (pending[gi])
    );
  end
endmodule
